// File: rtl/axis_i2c_byte.sv
// rtl/axis_i2c_byte.sv - byte-level I2C master sequencer feeding the I2C symbol PHY
module axis_i2c_byte #(
  parameter bit STOP_ON_NACK = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_cmd_valid,
  output logic        s_cmd_ready,
  input  logic [12:0] s_cmd_data,
  output logic        m_phy_valid,
  input  logic        m_phy_ready,
  output logic [2:0]  m_phy_data,
  input  logic        s_rx_valid,
  input  logic        s_rx_data,
  input  logic        s_rx_user,
  output logic        m_rsp_valid,
  input  logic        m_rsp_ready,
  output logic [7:0]  m_rsp_data,
  output logic        m_rsp_ack,
  output logic        m_rsp_err,
  output logic        bus_busy
);

  localparam logic [2:0] SYM_D0    = 3'd0;
  localparam logic [2:0] SYM_D1    = 3'd1;
  localparam logic [2:0] SYM_START = 3'd2;
  localparam logic [2:0] SYM_STOP  = 3'd3;
  localparam logic [2:0] SYM_ACK   = 3'd4;
  localparam logic [2:0] SYM_RX    = 3'd5;
  localparam logic [2:0] SYM_RS    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RS,
    ST_START,
    ST_BITS,
    ST_ACKS,
    ST_STOP,
    ST_RSP
  } state_t;

  state_t     state;
  state_t     next_state;

  logic       cmd_nodata;
  logic       cmd_start;
  logic       cmd_stop;
  logic       cmd_read;
  logic       cmd_nack;
  logic [7:0] wr_byte;
  logic [7:0] rx_byte;
  logic [2:0] bit_cnt;
  logic       ack_bit;
  logic       err_bit;

  logic       cmd_fire;
  logic       cmd_err;
  logic       ack_now;
  logic       stop_after_ack;

  // A data command on an idle bus without START has no bus to talk on.
  assign cmd_fire = (state == ST_IDLE) && s_cmd_valid && !rst;
  assign cmd_err  = !s_cmd_data[11] && !bus_busy && !s_cmd_data[12];

  // The slave's ack bit arrives with the ACK symbol's ready pulse, so use it directly.
  assign ack_now        = (s_rx_valid && s_rx_user) ? s_rx_data : ack_bit;
  assign stop_after_ack = cmd_stop || (STOP_ON_NACK && !cmd_read && ack_now);

  assign m_rsp_data = err_bit ? 8'h00 : (cmd_read ? rx_byte : wr_byte);
  assign m_rsp_ack  = ack_bit;
  assign m_rsp_err  = err_bit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state decode and symbol/handshake outputs.
  always_comb begin
    next_state  = state;
    s_cmd_ready = 1'b0;
    m_phy_valid = 1'b0;
    m_phy_data  = SYM_D0;
    m_rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        s_cmd_ready = !rst;
        if (cmd_fire) begin
          if (cmd_err)                        next_state = ST_RSP;
          else if (s_cmd_data[11] && bus_busy) next_state = ST_RS;
          else if (s_cmd_data[11])            next_state = ST_START;
          else if (s_cmd_data[12])            next_state = s_cmd_data[10] ? ST_STOP : ST_RSP;
          else                                next_state = ST_BITS;
        end
      end
      ST_RS: begin
        m_phy_valid = 1'b1;
        m_phy_data  = SYM_RS;
        if (m_phy_ready) next_state = ST_START;
      end
      ST_START: begin
        m_phy_valid = 1'b1;
        m_phy_data  = SYM_START;
        if (m_phy_ready) begin
          if (cmd_nodata) next_state = cmd_stop ? ST_STOP : ST_RSP;
          else            next_state = ST_BITS;
        end
      end
      ST_BITS: begin
        m_phy_valid = 1'b1;
        m_phy_data  = cmd_read ? SYM_RX : {2'b00, wr_byte[~bit_cnt]};
        if (m_phy_ready && (bit_cnt == 3'd7)) next_state = ST_ACKS;
      end
      ST_ACKS: begin
        m_phy_valid = 1'b1;
        if (cmd_read) m_phy_data = cmd_nack ? SYM_D1 : SYM_D0;
        else          m_phy_data = SYM_ACK;
        if (m_phy_ready) next_state = stop_after_ack ? ST_STOP : ST_RSP;
      end
      ST_STOP: begin
        m_phy_valid = 1'b1;
        m_phy_data  = SYM_STOP;
        if (m_phy_ready) next_state = ST_RSP;
      end
      ST_RSP: begin
        m_rsp_valid = 1'b1;
        if (m_rsp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Command latch, bit counter, receive shifter, ack/err capture and bus ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_nodata <= 1'b0;
      cmd_start  <= 1'b0;
      cmd_stop   <= 1'b0;
      cmd_read   <= 1'b0;
      cmd_nack   <= 1'b0;
      wr_byte    <= 8'h00;
      rx_byte    <= 8'h00;
      bit_cnt    <= 3'd0;
      ack_bit    <= 1'b0;
      err_bit    <= 1'b0;
      bus_busy   <= 1'b0;
    end else begin
      if (cmd_fire) begin
        cmd_nodata <= s_cmd_data[12];
        cmd_start  <= s_cmd_data[11];
        cmd_stop   <= s_cmd_data[10];
        cmd_read   <= s_cmd_data[9];
        cmd_nack   <= s_cmd_data[8];
        wr_byte    <= s_cmd_data[7:0];
        rx_byte    <= 8'h00;
        bit_cnt    <= 3'd0;
        ack_bit    <= cmd_err;
        err_bit    <= cmd_err;
      end
      if ((state == ST_START) && m_phy_ready) bus_busy <= 1'b1;
      if ((state == ST_STOP) && m_phy_ready)  bus_busy <= 1'b0;
      if (state == ST_BITS) begin
        if (s_rx_valid && !s_rx_user) rx_byte <= {rx_byte[6:0], s_rx_data};
        if (m_phy_ready)              bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == ST_ACKS) begin
        if (cmd_read)                      ack_bit <= cmd_nack;
        else if (s_rx_valid && s_rx_user)  ack_bit <= s_rx_data;
      end
    end
  end

endmodule

// File: tb/tb_axis_i2c_byte.sv
// tb/tb_axis_i2c_byte.sv - self-checking bench for axis_i2c_byte
module tb_axis_i2c_byte;

  localparam bit SON = 1'b1;

  localparam logic [2:0] D0 = 3'd0, D1 = 3'd1, START = 3'd2, STOP = 3'd3;
  localparam logic [2:0] ACK = 3'd4, RX = 3'd5, RS = 3'd6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_cmd_valid = 1'b0;
  logic        s_cmd_ready;
  logic [12:0] s_cmd_data = 13'h0;
  logic        m_phy_valid;
  logic        m_phy_ready = 1'b0;
  logic [2:0]  m_phy_data;
  logic        s_rx_valid = 1'b0;
  logic        s_rx_data = 1'b0;
  logic        s_rx_user = 1'b0;
  logic        m_rsp_valid;
  logic        m_rsp_ready = 1'b0;
  logic [7:0]  m_rsp_data;
  logic        m_rsp_ack;
  logic        m_rsp_err;
  logic        bus_busy;

  axis_i2c_byte #(.STOP_ON_NACK(SON)) dut (
    .clk(clk), .rst(rst),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_data(s_cmd_data),
    .m_phy_valid(m_phy_valid), .m_phy_ready(m_phy_ready), .m_phy_data(m_phy_data),
    .s_rx_valid(s_rx_valid), .s_rx_data(s_rx_data), .s_rx_user(s_rx_user),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_data(m_rsp_data),
    .m_rsp_ack(m_rsp_ack), .m_rsp_err(m_rsp_err),
    .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_sym[$];
  logic [9:0] exp_rsp[$];
  logic       slave_q[$];
  logic       m_busy = 1'b0;
  int         sym_cnt = 0;
  int         rsp_hold = 0;
  logic [9:0] last_rsp = 10'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected symbols, slave answers and response for one command, from the byte-level rules.
  task automatic model_cmd(input logic [12:0] c, input logic [7:0] sbyte, input logic sack);
    logic nodata, st, sp, rd, nk, ack;
    logic [7:0] wb, d;
    nodata = c[12]; st = c[11]; sp = c[10]; rd = c[9]; nk = c[8]; wb = c[7:0];
    if (!st && !m_busy && !nodata) begin
      exp_rsp.push_back({8'h00, 1'b1, 1'b1});
    end else begin
      ack = 1'b0;
      d   = rd ? 8'h00 : wb;
      if (st) begin
        if (m_busy) exp_sym.push_back(RS);
        exp_sym.push_back(START);
        m_busy = 1'b1;
      end
      if (!nodata) begin
        for (int i = 7; i >= 0; i--) begin
          if (rd) begin
            exp_sym.push_back(RX);
            slave_q.push_back(sbyte[i]);
          end else begin
            exp_sym.push_back(wb[i] ? D1 : D0);
          end
        end
        if (rd) begin
          exp_sym.push_back(nk ? D1 : D0);
          ack = nk;
          d   = sbyte;
        end else begin
          exp_sym.push_back(ACK);
          slave_q.push_back(sack);
          ack = sack;
        end
      end
      if (sp || (SON && !rd && !nodata && ack)) begin
        exp_sym.push_back(STOP);
        m_busy = 1'b0;
      end
      exp_rsp.push_back({d, ack, 1'b0});
    end
  endtask

  // PHY stand-in: consumes each symbol after two cycles, answering RX/ACK slots from slave_q.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || !m_phy_valid || m_phy_ready) begin
        m_phy_ready = 1'b0; s_rx_valid = 1'b0; s_rx_user = 1'b0; s_rx_data = 1'b0; wcnt = 0;
      end else begin
        wcnt++;
        if (wcnt >= 2) begin
          m_phy_ready = 1'b1;
          if ((m_phy_data == RX || m_phy_data == ACK) && slave_q.size() > 0) begin
            s_rx_valid = 1'b1;
            s_rx_user  = (m_phy_data == ACK);
            s_rx_data  = slave_q.pop_front();
          end
        end
      end
    end
  end

  // Response sink: holds ready low for rsp_hold cycles of a presented response.
  initial begin
    int hcnt;
    hcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (m_rsp_valid && !m_rsp_ready) begin
        hcnt++;
        if (hcnt > rsp_hold) m_rsp_ready = 1'b1;
      end else begin
        m_rsp_ready = 1'b0;
        hcnt = 0;
      end
    end
  end

  // Compare process: every symbol and response against the model queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_sym.size() == 0) chk("phy_idle", m_phy_valid, 1'b0);
      else if (m_phy_valid) begin
        chk("sym", m_phy_data, exp_sym[0]);
        if (m_phy_ready) begin
          void'(exp_sym.pop_front());
          sym_cnt++;
        end
      end
      if (exp_rsp.size() == 0 || exp_sym.size() != 0) chk("rsp_idle", m_rsp_valid, 1'b0);
      else if (m_rsp_valid) begin
        chk("rsp", {m_rsp_data, m_rsp_ack, m_rsp_err}, exp_rsp[0]);
        if (m_rsp_ready) begin
          last_rsp = exp_rsp.pop_front();
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [12:0] c, input int nsym);
    bit got;
    got = 0;
    s_cmd_data  = c;
    s_cmd_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (s_cmd_ready) begin got = 1; break; end
    end
    chk({nm, "_accept"}, got, 1);
    @(posedge clk); #1;
    s_cmd_valid = 1'b0;
    chk({nm, "_lat_phy"}, m_phy_valid, nsym > 0);
    chk({nm, "_lat_rsp"}, m_rsp_valid, nsym == 0);
  endtask

  task automatic do_cmd(input string nm, input logic [12:0] c, input logic [7:0] sb,
                        input logic sa, input int hold);
    int nsym;
    bit done;
    model_cmd(c, sb, sa);
    nsym     = exp_sym.size();
    sym_cnt  = 0;
    rsp_hold = hold;
    issue(nm, c, nsym);
    done = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (exp_rsp.size() == 0) begin done = 1; break; end
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy"}, bus_busy, m_busy);
    chk({nm, "_ready"}, s_cmd_ready, 1'b1);
  endtask

  initial begin
    bit got;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", s_cmd_ready, 1'b0);
    chk("rst_phy", {m_phy_valid, m_phy_data}, 4'h0);
    chk("rst_rsp", {m_rsp_valid, m_rsp_data, m_rsp_ack, m_rsp_err}, 11'h0);
    chk("rst_busy", bus_busy, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", s_cmd_ready, 1'b1);

    do_cmd("w_a5", 13'h08A5, 8'h00, 1'b0, 0);
    chk("w_a5_nsym", sym_cnt, 10);
    chk("w_a5_rsp", last_rsp, {8'hA5, 1'b0, 1'b0});
    chk("w_a5_busy_lit", bus_busy, 1'b1);

    do_cmd("rd_b2", 13'h0700, 8'hB2, 1'b0, 2);
    chk("rd_b2_nsym", sym_cnt, 10);
    chk("rd_b2_rsp", last_rsp, {8'hB2, 1'b1, 1'b0});
    chk("rd_b2_busy_lit", bus_busy, 1'b0);

    do_cmd("w_50", 13'h0850, 8'h00, 1'b0, 0);
    do_cmd("rs_rd", 13'h0E00, 8'h5A, 1'b0, 0);
    chk("rs_rd_nsym", sym_cnt, 12);
    chk("rs_rd_rsp", last_rsp, {8'h5A, 1'b0, 1'b0});

    do_cmd("w_3c_nack", 13'h083C, 8'h00, 1'b1, 3);
    chk("w_3c_nsym", sym_cnt, 11);
    chk("w_3c_rsp", last_rsp, {8'h3C, 1'b1, 1'b0});
    chk("w_3c_busy_lit", bus_busy, 1'b0);

    do_cmd("err_rd", 13'h0200, 8'h00, 1'b0, 0);
    chk("err_nsym", sym_cnt, 0);
    chk("err_rsp", last_rsp, {8'h00, 1'b1, 1'b1});

    do_cmd("nodata", 13'h1C00, 8'h00, 1'b0, 0);
    chk("nodata_nsym", sym_cnt, 2);

    // Reset in the middle of a write, after START and four data symbols.
    model_cmd(13'h0896, 8'h00, 1'b0);
    sym_cnt = 0;
    issue("rst_mid", 13'h0896, exp_sym.size());
    got = 0;
    for (int n = 0; n < 200; n++) begin
      if (sym_cnt >= 5) begin got = 1; break; end
      @(posedge clk); #1;
    end
    chk("rst_mid_reach", got, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_phy", m_phy_valid, 1'b0);
    chk("rst_mid_busy", bus_busy, 1'b0);
    chk("rst_mid_ready", s_cmd_ready, 1'b0);
    exp_sym.delete();
    exp_rsp.delete();
    slave_q.delete();
    m_busy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_ready_after", s_cmd_ready, 1'b1);

    do_cmd("after_rst", 13'h0CC3, 8'h00, 1'b0, 0);
    chk("after_rst_nsym", sym_cnt, 11);
    chk("after_rst_rsp", last_rsp, {8'hC3, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/axis_i2c_byte.md
# axis_i2c_byte

Byte-level I2C master sequencer that sits directly upstream of the I2C symbol PHY (`axis_i2c_sphy`). It accepts one byte command at a time and expands it into the PHY's 3-bit symbol stream: optional repeated start, start, 8 data or receive bits, an acknowledge slot, and optional stop. It reassembles the PHY's received bits into a byte plus ACK status, and returns them on a response stream.

## Interface
Parameters:
- `STOP_ON_NACK`, default 0: when 1, a NACK on a write acknowledge slot forces a STOP symbol, even if the command's stop flag is clear.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `s_cmd_valid` in 1: command valid.
- `s_cmd_ready` out 1: command accepted.
- `s_cmd_data` in 13: command word.
  - [12] nodata
  - [11] start
  - [10] stop
  - [9] read
  - [8] nack (read only: master sends NACK)
  - [7:0] write byte
- `m_phy_valid` out 1: symbol valid; connects to the PHY's `s_tx_valid`.
- `m_phy_ready` in 1: symbol consumed; connects to the PHY's `s_tx_ready`.
- `m_phy_data` out 3: symbol code. D0=0, D1=1, START=2, STOP=3, ACK=4, RX=5, RS=6.
- `s_rx_valid` in 1: PHY bit valid.
- `s_rx_data` in 1: PHY received bit.
- `s_rx_user` in 1: 1 when the bit is the ACK-slot bit.
- `m_rsp_valid` out 1: response valid.
- `m_rsp_ready` in 1: response accepted.
- `m_rsp_data` out 8: read byte (read commands) or echo of the write byte.
- `m_rsp_ack` out 1: ACK-slot value. 0 = ACK; the slave's bit for writes, the master's bit for reads.
- `m_rsp_err` out 1: protocol error; command dropped.
- `bus_busy` out 1: a START has been issued and no STOP has been issued since.

## Operation
- States: IDLE, RS, START, BITS, ACKS, STOP, RSP.
- IDLE: `s_cmd_ready`=1. On handshake, latch the command, then:
  - If start=0 and `bus_busy`=0 and nodata=0: go to RSP with err=1; no symbols are emitted.
  - Else if start=1 and `bus_busy`=1: go to RS.
  - Else if start=1: go to START.
  - Else if nodata=1: go to STOP if stop=1, otherwise to RSP.
  - Else: go to BITS.
- RS: emit RS, then go to START.
- START: emit START and set `bus_busy`. Then go to BITS, or if nodata=1, to STOP (stop=1) or RSP.
- BITS: 8 symbols, MSB first, counted by a 3-bit counter.
  - Write: D0 or D1 per byte bit.
  - Read: RX.
  - Each `s_rx_valid` with `s_rx_user`=0 shifts `s_rx_data` into the byte register LSB-side.
- ACKS:
  - Write: emit ACK and capture the ack bit on `s_rx_valid` with `s_rx_user`=1.
  - Read: emit D1 if nack=1, else D0; the ack bit equals nack.
  - Next state is STOP if stop=1, or if (`STOP_ON_NACK`=1, write, ack bit=1). Otherwise RSP.
- STOP: emit STOP, clear `bus_busy`, go to RSP.
- RSP: `m_rsp_valid`=1 with stable data, ack and err until `m_rsp_ready`; then go to IDLE.
- Every command produces exactly one response, including nodata and error commands.
- A write response echoes the write byte on `m_rsp_data`.
- An error response has data=0 and ack=1.

## Timing
- A symbol is held on `m_phy_data` with `m_phy_valid`=1 until the `m_phy_ready` pulse.
- The next symbol of the same command is registered on the cycle after that pulse; there is no invalid gap within a command. The PHY's CLOCK_DIV must be ≥2.
- `m_phy_valid`=0 in IDLE and RSP. With no symbol presented, the PHY holds the bus: SCL low between bytes, both lines released after STOP.
- `s_rx_valid` coincides with `m_phy_ready` for RX and ACK symbols. Received bits are captured in that same cycle.
- Symbol counts per command:
  - write: 9
  - with start: +1
  - with repeated start: +2
  - with stop: +1
  - maximum: 12
- Latency:
  - command handshake to first `m_phy_valid`: 1 cycle.
  - final `m_phy_ready` to `m_rsp_valid`: 1 cycle.
  - error or empty command: `m_rsp_valid` 1 cycle after the command handshake.
- `m_rsp_valid` and `m_rsp_ready` may both be high on the response-presenting cycle. The next `s_cmd_ready` follows 1 cycle later.
- Reset values:
  - `s_cmd_ready`=0 during reset, 1 in the cycle after reset.
  - `m_phy_valid`=0, `m_phy_data`=0.
  - `m_rsp_valid`=0, data/ack/err=0.
  - `bus_busy`=0.
  - state IDLE.
- Reset mid-command abandons the command immediately. No STOP is generated; the PHY shares `rst` and releases both lines.
- `s_rx_valid` outside BITS/ACKS, or with a `s_rx_user` value that does not match the current state, is ignored.

## Test plan
- Write 0xA5, start=1, stop=0, slave ACK=0 → symbols START,D1,D0,D1,D0,D0,D1,D0,D1,ACK. Response data=0xA5, ack=0, err=0. `bus_busy`=1 afterwards.
- Read, nack=1, stop=1, slave bits 1,0,1,1,0,0,1,0 → symbols RX×8, D1, STOP. Response data=0xB2, ack=1. `bus_busy`=0.
- Repeated start: write 0x50 with start (no stop), then read with start=1 → second command emits RS then START, followed by RX×8.
- `STOP_ON_NACK`=1, write 0x3C with slave NACK and stop=0 → STOP emitted after ACK. Response ack=1. `bus_busy`=0.
- Idle bus, command start=0 read → no `m_phy_valid`. Response err=1, data=0, ack=1 one cycle after the handshake.
- Assert `rst` after the 4th data symbol → next cycle `m_phy_valid`=0, `bus_busy`=0. After release, `s_cmd_ready`=1, and a new start+write executes normally.
